// File: rtl/sprite_line_prefetcher_if.sv
// Bus bundle between the sprite line prefetcher, the maze map RAM, the
// sprite table and the VGA timing/colour mapper.
interface sprite_line_prefetcher_if;
    logic              start;
    logic [9:0]        line_y;
    logic              swap;
    logic              busy;
    logic              done;
    logic [10:0]       tile_addr;
    logic [4:0]        tile_data;
    logic [4:0]        sprite_index;
    logic [15:0][15:0] sprite;
    logic [9:0]        pix_x;
    logic              pixel;

    // Prefetcher side
    modport slave (
        input  start, line_y, swap, tile_data, sprite, pix_x,
        output busy, done, tile_addr, sprite_index, pixel
    );

    // Video timing / memory side
    modport master (
        output start, line_y, swap, tile_data, sprite, pix_x,
        input  busy, done, tile_addr, sprite_index, pixel
    );
endinterface

// File: rtl/sprite_line_prefetcher.sv
// Per-scanline sprite fetch engine. During horizontal blank it walks one
// maze-map tile row, looks up each tile's sprite row and fills the back half
// of a double-buffered line buffer; during active video it serves the
// foreground pixel for the current x from the front half.
module sprite_line_prefetcher #(
    parameter int TILES_X = 40,
    parameter int TILES_Y = 30
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    sprite_line_prefetcher_if.slave  bus
);

    localparam logic [10:0] LINE_LIMIT = 11'(16 * TILES_Y);
    localparam logic [10:0] PIX_LIMIT  = 11'(16 * TILES_X);
    localparam logic [5:0]  LAST_COL   = 6'(TILES_X - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t      r_state;
    logic [9:0]  r_ly;
    logic [5:0]  r_col;
    logic        r_busy;
    logic        r_done;
    logic [10:0] r_tile_addr;
    logic [4:0]  r_sprite_index;
    logic        r_sel;
    logic        r_swap_pending;
    logic        r_pixel;
    logic [15:0] r_bank [2][TILES_X];

    logic [15:0] w_capture_row;
    logic        w_pix_on;
    logic [5:0]  w_pix_slot;
    logic [3:0]  w_pix_bit;
    logic [15:0] w_front_row;

    // Lines below the visible area fetch nothing and fill the buffer with blanks.
    function automatic logic f_offscreen(input logic [9:0] ly);
        return {1'b0, ly} >= LINE_LIMIT;
    endfunction

    // Map RAM address of column col in the tile row covering scanline ly.
    function automatic logic [10:0] f_tile_addr(input logic [9:0] ly, input logic [5:0] col);
        if (f_offscreen(ly)) begin
            return '0;
        end
        return (11'(ly[9:4]) * 11'(TILES_X)) + 11'(col);
    endfunction

    assign w_capture_row = f_offscreen(r_ly) ? 16'h0000 : bus.sprite[r_ly[3:0]];

    // Column position within the slot is mirrored: bit 15 is the leftmost pixel.
    assign w_pix_on    = ({1'b0, bus.pix_x} < PIX_LIMIT);
    assign w_pix_slot  = w_pix_on ? bus.pix_x[9:4] : 6'd0;
    assign w_pix_bit   = ~bus.pix_x[3:0];
    assign w_front_row = r_bank[r_sel][w_pix_slot];

    // Fetch sequencer: one tile per ADDR/WAIT/CAPTURE round, outputs registered.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= S_IDLE;
            r_ly           <= '0;
            r_col          <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_tile_addr    <= '0;
            r_sprite_index <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_ly        <= bus.line_y;
                        r_col       <= '0;
                        r_busy      <= 1'b1;
                        r_tile_addr <= f_tile_addr(bus.line_y, 6'd0);
                        r_state     <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_sprite_index <= bus.tile_data;
                    r_state        <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    if (r_col == LAST_COL) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_col       <= r_col + 6'd1;
                        r_tile_addr <= f_tile_addr(r_ly, r_col + 6'd1);
                        r_state     <= S_ADDR;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Bank select: swaps apply immediately when idle, otherwise are held until the fetch ends.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sel          <= 1'b0;
            r_swap_pending <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.swap) begin
                        r_sel <= ~r_sel;
                    end
                end
                S_DONE: begin
                    if (bus.swap || r_swap_pending) begin
                        r_sel <= ~r_sel;
                    end
                    r_swap_pending <= 1'b0;
                end
                default: begin
                    if (bus.swap) begin
                        r_swap_pending <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Line buffer: CAPTURE writes only the back bank, addressed by the opposite of sel.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < TILES_X; i++) begin
                    r_bank[b][i] <= '0;
                end
            end
        end else if (r_state == S_CAPTURE) begin
            r_bank[~r_sel][r_col] <= w_capture_row;
        end
    end

    // Pixel output: front-bank bit for pix_x, blank beyond the right edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pixel <= 1'b0;
        end else begin
            r_pixel <= w_pix_on & w_front_row[w_pix_bit];
        end
    end

    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.tile_addr    = r_tile_addr;
    assign bus.sprite_index = r_sprite_index;
    assign bus.pixel        = r_pixel;

endmodule

// File: tb/tb_sprite_line_prefetcher.sv
// Bench for sprite_line_prefetcher: map RAM and sprite table models plus a
// line-level reference of the front/back buffers.
module tb_sprite_line_prefetcher;

    logic clk;
    logic rst_n;

    sprite_line_prefetcher_if bus ();

    sprite_line_prefetcher dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memories seen by the DUT
    logic [4:0]        map_ram [2048];
    logic [15:0][15:0] spr_tab [32];

    always @(posedge clk) bus.tile_data <= map_ram[bus.tile_addr];
    assign bus.sprite = spr_tab[bus.sprite_index];

    // Reference: displayed line and pending line, as plain pixel arrays
    bit ref_front [640];
    bit ref_back  [640];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit line_pixel(input int ly, input int x);
        logic [15:0] row;
        int          t;
        if (ly >= 480 || x >= 640) return 1'b0;
        t   = int'(map_ram[(ly / 16) * 40 + x / 16]);
        row = spr_tab[t][ly % 16];
        return row[15 - x % 16];
    endfunction

    task automatic ref_swap();
        bit tmp;
        for (int x = 0; x < 640; x++) begin
            tmp         = ref_front[x];
            ref_front[x] = ref_back[x];
            ref_back[x]  = tmp;
        end
    endtask

    task automatic swap_idle();
        bus.swap = 1'b1;
        tick();
        bus.swap = 1'b0;
        ref_swap();
        tick();
    endtask

    task automatic scan_line(input string tag);
        for (int x = 0; x <= 640; x++) begin
            bus.pix_x = 10'(x);
            tick();
            check(tag, 32'(bus.pixel), 32'((x < 640) ? ref_front[x] : 1'b0));
        end
        bus.pix_x = 10'd1023;
        tick();
        check({tag, "_x1023"}, 32'(bus.pixel), 32'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"},  32'(bus.busy), 32'd0);
        check({tag, "_done"},  32'(bus.done), 32'd0);
        check({tag, "_pixel"}, 32'(bus.pixel), 32'd0);
        check({tag, "_taddr"}, 32'(bus.tile_addr), 32'd0);
        check({tag, "_sidx"},  32'(bus.sprite_index), 32'd0);
    endtask

    // One complete fetch with optional swap/start pulses at given edges after the start edge.
    task automatic fetch(input string tag, input int ly, input int sw_a, input int sw_b,
                         input int st_a, input bit st_on_done);
        bit pend;
        int prev_x;
        int ndone;
        pend  = 1'b0;
        ndone = 0;
        prev_x = int'(bus.pix_x);
        bus.line_y = 10'(ly);
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        for (int k = 0; k <= 125; k++) begin
            if (k < 120 && (k % 3) == 0) begin
                check({tag, "_taddr"}, 32'(bus.tile_addr),
                      (ly < 480) ? 32'((ly / 16) * 40 + k / 3) : 32'd0);
            end
            check({tag, "_busy"}, 32'(bus.busy), 32'(k < 120));
            check({tag, "_done"}, 32'(bus.done), 32'(k == 120));
            if (bus.done) ndone++;
            if (k >= 1 && k <= 120) begin
                check({tag, "_oldpix"}, 32'(bus.pixel),
                      32'((prev_x < 640) ? ref_front[prev_x] : 1'b0));
            end
            bus.swap  = ((k + 1) == sw_a) || ((k + 1) == sw_b);
            if (bus.swap) pend = 1'b1;
            bus.start = ((k + 1) == st_a) || (st_on_done && (k + 1) == 121);
            prev_x    = int'($urandom_range(0, 700));
            bus.pix_x = 10'(prev_x);
            tick();
        end
        bus.swap  = 1'b0;
        bus.start = 1'b0;
        check({tag, "_ndone"}, 32'(ndone), 32'd1);
        for (int x = 0; x < 640; x++) ref_back[x] = line_pixel(ly, x);
        if (pend) ref_swap();
    endtask

    task automatic randomize_map();
        for (int i = 0; i < 2048; i++) map_ram[i] = 5'($urandom);
    endtask

    initial begin
        logic [15:0] pat;
        int          ly;

        for (int s = 0; s < 32; s++)
            for (int r = 0; r < 16; r++)
                spr_tab[s][r] = 16'($urandom);
        spr_tab[1][7] = 16'hE1C3;
        for (int i = 0; i < 2048; i++) map_ram[i] = 5'd0;
        for (int x = 0; x < 640; x++) begin
            ref_front[x] = 1'b0;
            ref_back[x]  = 1'b0;
        end

        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.swap   = 1'b0;
        bus.line_y = '0;
        bus.pix_x  = '0;
        tick();
        tick();
        check_outputs_zero("reset");
        rst_n = 1'b1;
        tick();
        scan_line("reset_pix");

        // Full fetch: every tile is sprite 1, row 7
        for (int i = 0; i < 2048; i++) map_ram[i] = 5'd1;
        fetch("full", 7, -1, -1, -1, 1'b0);
        swap_idle();
        pat = 16'hE1C3;
        for (int x = 0; x < 16; x++) begin
            bus.pix_x = 10'(x);
            tick();
            check("full_pattern", 32'(bus.pixel), 32'(pat[15 - x]));
        end
        scan_line("full_pix");

        // Row offset and row select: row 2, sprite row 3, one odd tile at address 85
        for (int i = 0; i < 2048; i++) map_ram[i] = 5'd5;
        map_ram[85] = 5'd0;
        fetch("rowsel", 35, -1, -1, -1, 1'b0);
        swap_idle();
        scan_line("rowsel_pix");

        // Off-screen line writes blanks and keeps the address at 0
        randomize_map();
        fetch("offscr", 480, -1, -1, -1, 1'b0);
        swap_idle();
        scan_line("offscr_pix");

        // Swaps during the fetch collapse into one toggle at the end
        randomize_map();
        ly = int'($urandom_range(0, 479));
        fetch("swapbusy", ly, 10, 50, -1, 1'b0);
        scan_line("swapbusy_pix");

        // Restart attempts mid-fetch and on the done cycle are ignored
        randomize_map();
        ly = int'($urandom_range(0, 479));
        fetch("overlap", ly, -1, -1, 60, 1'b1);
        swap_idle();
        scan_line("overlap_pix");

        // Reset in the middle of a fetch, at column 17
        randomize_map();
        bus.line_y = 10'($urandom_range(0, 479));
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        repeat (52) tick();
        check("pre_rst_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("rst_async");
        tick();
        check_outputs_zero("rst_cycle");
        rst_n = 1'b1;
        for (int x = 0; x < 640; x++) begin
            ref_front[x] = 1'b0;
            ref_back[x]  = 1'b0;
        end
        tick();
        scan_line("rst_pix");
        swap_idle();
        scan_line("rst_pix_other");

        ly = int'($urandom_range(0, 479));
        fetch("after_rst", ly, -1, -1, -1, 1'b0);
        swap_idle();
        scan_line("after_rst_pix");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sprite_line_prefetcher.md
# sprite_line_prefetcher

Per-scanline sprite fetch engine for the maze display. During horizontal blanking it walks the 40-tile row of the maze map that covers the next scanline, looks up each tile's sprite in the sprite table and stores the selected 16-bit row into the back half of a double-buffered 640-bit line buffer. During active video it returns the foreground pixel for the current x from the front half. It sits between the VGA timing/colour mapper and the maze map RAM + sprite table.

## Interface
- TILES_X, 40, tiles per row (tile width fixed at 16 px)
- TILES_Y, 30, tile rows (line_y < 16*TILES_Y is on-screen)
- Clk  in  1  system clock (25 MHz pixel clock)
- Reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse: begin filling back bank for line_y
- line_y  in  10  scanline to prefetch, sampled on start
- swap  in  1  one-cycle pulse: exchange front/back banks
- busy  out  1  fetch in progress
- done  out  1  one-cycle pulse after the last tile is written
- tile_addr  out  11  maze map RAM address = (line_y>>4)*TILES_X + col
- tile_data  in  5  maze map RAM read data, valid one cycle after tile_addr
- sprite_index  out  5  to sprite table
- sprite  in  16x16  sprite bitmap from sprite table (combinational on sprite_index), row r = sprite[r], bit 15 = leftmost pixel
- pix_x  in  10  current display x
- pixel  out  1  foreground bit for pix_x, one-cycle latency

## Operation
- FSM: IDLE, ADDR, WAIT, CAPTURE, DONE.
- IDLE: start=1 latches line_y into ly, clears col → ADDR. start while not IDLE is ignored.
- ADDR: drive tile_addr for (ly[9:4], col) → WAIT.
- WAIT: register tile_data into sprite_index → CAPTURE.
- CAPTURE: write sprite[ly[3:0]] into back-bank slot col. If col == TILES_X-1 → DONE, else col+1 → ADDR.
- DONE: done=1 for one cycle → IDLE.
- Off-screen line (ly >= 16*TILES_Y): the sequence and cycle count are unchanged, but every slot is written with 16'h0000. tile_addr is held at 0.
- Bank select: one register, front = bank[sel], back = bank[~sel].
- swap in IDLE or DONE toggles sel on that edge.
- swap while busy sets swap_pending. The toggle takes effect on the DONE edge, so the new front bank is the one just filled. Multiple swaps while busy collapse to one.
- Pixel path: pixel <= (pix_x < 16*TILES_X) ? front[pix_x[9:4]][15 - pix_x[3:0]] : 0. Registered; reads use the sel value in effect before the same-edge toggle.
- CAPTURE never writes the front bank.
- Reset (any time, including mid-fetch): FSM to IDLE, col=0, sel=0, swap_pending=0, both banks cleared to 0. All outputs are 0 while Reset_n is low: busy, done, pixel, tile_addr, sprite_index.

## Timing
- start sampled at edge 0 → busy=1 from edge 1.
- Each tile takes 3 cycles (ADDR, WAIT, CAPTURE), so 40 tiles take 120 cycles.
- Last CAPTURE is on edge 120. DONE cycle: done=1 and busy=0 on edge 121. IDLE on edge 122.
- Total 121 cycles, which fits inside the 160-cycle horizontal blank.
- tile_addr is registered and changes on entry to ADDR. The map RAM must be synchronous with one-cycle read latency.
- The sprite table must settle within one cycle of sprite_index.
- pixel reflects pix_x from the previous edge.
- start on the same edge as DONE is ignored; it is accepted only in IDLE.

## Test plan
- Reset: assert Reset_n=0 mid-fetch (col=17) → all outputs 0 next cycle. After release, pixel=0 for every pix_x, and a new start completes normally.
- Full fetch: map all tile 1, line_y=7 → tile_addr sequence 0,1,…,39, done on edge 121. After swap, pix_x=0..15 yields 1110000111000011 and pixel=0 at pix_x=640.
- Row offset / row select: line_y=35 (row 2, r=3), map tile at address 85 = 0 with all others 5 → tile_addr 80..119 observed. After swap, pix_x 80..95 matches sprite 0 row 3 and the other slots match sprite 5 row 3.
- Off-screen: line_y=480 → done after 121 cycles, tile_addr stays 0, and after swap every pixel is 0.
- Swap while busy: swap pulses at cycles 10 and 50 → front bank unchanged until the DONE edge, then exactly one toggle. Pixels read before DONE come from the old bank.
- Overlap: start pulsed again at cycle 60 and on the DONE cycle → both ignored, col sequence not restarted, a single done pulse.
